// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI responder: register map, flag bit positions and
// the byte shifted out when firmware has nothing queued.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_STATUS = 2'd1,
        REG_TXDATA = 2'd2,
        REG_RXDATA = 2'd3
    } reg_idx_e;

    localparam int CTRL_EN_BIT         = 0;
    localparam int CTRL_IRQ_EN_BIT     = 1;

    localparam int STATUS_RX_VALID_BIT = 0;
    localparam int STATUS_TX_VALID_BIT = 1;
    localparam int STATUS_OVR_BIT      = 2;
    localparam int STATUS_BUSY_BIT     = 3;

    localparam logic [7:0] IDLE_TX_BYTE = 8'h00;
    localparam logic [2:0] LAST_BIT     = 3'd7;

    function automatic logic [7:0] shift_in(input logic [7:0] s, input logic b);
        return {s[6:0], b};
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin, with single-cycle rise/fall
// pulses taken from a third (edge-history) register.
module spi_slave_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic d_p0, d_p1, d_p2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_p0 <= RESET_VAL;
            d_p1 <= RESET_VAL;
            d_p2 <= RESET_VAL;
        end else begin
            d_p0 <= d;
            d_p1 <= d_p0;
            d_p2 <= d_p1;
        end
    end

    assign q    = d_p1;
    assign rise = d_p1 & ~d_p2;
    assign fall = ~d_p1 & d_p2;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder for the TRSQ8 peripheral bus: one TX and one RX byte buffer.
// Optional interrupt output is built when SPI_SLAVE_IRQ_EN is defined.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int ADDR_LSB          = 0,
    parameter int OPT_MEM_ADDR_BITS = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ss_n,
    output logic       miso,
    output logic       miso_oe
`ifdef SPI_SLAVE_IRQ_EN
    ,
    output logic       irq
`endif
);

    localparam int IDX_W = OPT_MEM_ADDR_BITS + 1;

    logic [IDX_W-1:0] reg_idx;
    logic             addr_unused;
    logic             sclk_level_unused;
    logic [1:0]       mosi_edges_unused;

    logic sclk_rise, sclk_fall;
    logic ss_q, ss_rise, ss_fall;
    logic mosi_q;

    logic       en, irq_en;
    logic       rx_valid, tx_valid, ovr;
    logic [7:0] tx_buf, rx_buf, tx_shift, rx_shift;
    logic [2:0] bit_cnt;

    logic wr_ctrl, wr_status, wr_tx, rd_rx;
    logic selected, sclk_rise_sel, byte_done, rx_accept, overrun;
    logic tx_load, tx_shift_en;
    logic [7:0] ctrl_rd, status_rd;

    spi_slave_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .d(sclk),
        .q(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_slave_sync #(.RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset_n(reset_n), .d(ss_n),
        .q(ss_q), .rise(ss_rise), .fall(ss_fall)
    );

    spi_slave_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .d(mosi),
        .q(mosi_q), .rise(mosi_edges_unused[0]), .fall(mosi_edges_unused[1])
    );

    // Upper address bits are decoded by the bus fabric before wr_en/rd_en arrive.
    assign addr_unused = ^addr;
    assign reg_idx     = addr[ADDR_LSB+OPT_MEM_ADDR_BITS : ADDR_LSB];

    assign wr_ctrl   = wr_en && (reg_idx == IDX_W'(REG_CTRL));
    assign wr_status = wr_en && (reg_idx == IDX_W'(REG_STATUS));
    assign wr_tx     = wr_en && (reg_idx == IDX_W'(REG_TXDATA));
    assign rd_rx     = rd_en && (reg_idx == IDX_W'(REG_RXDATA));

    assign selected      = en & miso_oe & ~ss_q;
    assign sclk_rise_sel = selected & sclk_rise;
    assign byte_done     = sclk_rise_sel & (bit_cnt == LAST_BIT);
    // A read landing on the completing edge frees the buffer for the new byte.
    assign rx_accept     = ~rx_valid | rd_rx;
    assign overrun       = byte_done & ~rx_accept;
    assign tx_load       = en & (ss_fall | (selected & sclk_fall & (bit_cnt == 3'd0)));
    assign tx_shift_en   = selected & sclk_fall & (bit_cnt != 3'd0);

    assign miso = selected & tx_shift[7];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en       <= 1'b0;
            rx_valid <= 1'b0;
            tx_valid <= 1'b0;
            ovr      <= 1'b0;
            tx_buf   <= 8'h00;
            rx_buf   <= 8'h00;
            tx_shift <= 8'h00;
            rx_shift <= 8'h00;
            bit_cnt  <= 3'd0;
            miso_oe  <= 1'b0;
        end else begin
            if (wr_ctrl)
                en <= din[CTRL_EN_BIT];

            if (wr_tx) begin
                tx_buf   <= din;
                tx_valid <= 1'b1;
            end else if (tx_load) begin
                tx_valid <= 1'b0;
            end

            if (tx_load)
                tx_shift <= tx_valid ? tx_buf : IDLE_TX_BYTE;
            else if (tx_shift_en)
                tx_shift <= {tx_shift[6:0], 1'b0};

            if (sclk_rise_sel)
                rx_shift <= shift_in(rx_shift, mosi_q);
            if (byte_done && rx_accept)
                rx_buf <= shift_in(rx_shift, mosi_q);

            if (byte_done && rx_accept)
                rx_valid <= 1'b1;
            else if (rd_rx)
                rx_valid <= 1'b0;

            if (overrun)
                ovr <= 1'b1;
            else if (wr_status && din[STATUS_OVR_BIT])
                ovr <= 1'b0;

            if (!en || ss_rise) begin
                bit_cnt <= 3'd0;
                miso_oe <= 1'b0;
            end else if (ss_fall) begin
                bit_cnt <= 3'd0;
                miso_oe <= 1'b1;
            end else if (sclk_rise_sel) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

`ifdef SPI_SLAVE_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_ctrl)
                irq_en <= din[CTRL_IRQ_EN_BIT];
            irq <= irq_en & en & (rx_valid | ovr);
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    always_comb begin
        ctrl_rd                  = 8'h00;
        ctrl_rd[CTRL_EN_BIT]     = en;
        ctrl_rd[CTRL_IRQ_EN_BIT] = irq_en;

        status_rd                      = 8'h00;
        status_rd[STATUS_RX_VALID_BIT] = rx_valid;
        status_rd[STATUS_TX_VALID_BIT] = tx_valid;
        status_rd[STATUS_OVR_BIT]      = ovr;
        status_rd[STATUS_BUSY_BIT]     = en & ~ss_q;
    end

    always_comb begin
        dout = 8'h00;
        case (reg_idx)
            IDX_W'(REG_CTRL):   dout = ctrl_rd;
            IDX_W'(REG_STATUS): dout = status_rd;
            IDX_W'(REG_RXDATA): dout = rx_buf;
            default:            dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed register/frame scenarios followed by random traffic,
// checked against a transaction-level model of the register file and the SPI byte stream.
module tb_spi_slave;

    localparam logic [7:0] A_CTRL   = 8'h88;
    localparam logic [7:0] A_STATUS = 8'h89;
    localparam logic [7:0] A_TX     = 8'h8A;
    localparam logic [7:0] A_RX     = 8'h8B;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] addr, din, dout;
    logic       wr_en, rd_en, sclk, mosi, ss_n, miso, miso_oe;
`ifdef SPI_SLAVE_IRQ_EN
    logic       irq;
`endif

    always #5 clk = ~clk;

    spi_slave #(.ADDR_LSB(0), .OPT_MEM_ADDR_BITS(1)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .din(din), .dout(dout),
        .wr_en(wr_en), .rd_en(rd_en), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
        .miso(miso), .miso_oe(miso_oe)
`ifdef SPI_SLAVE_IRQ_EN
        , .irq(irq)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit quiet   = 1'b0;
    logic [7:0] last_collide_rd = 8'h00;

    // Model state: what firmware would see after every transaction has settled.
    bit         m_en, m_irq_en, m_rx_valid, m_tx_valid, m_ovr;
    logic [7:0] m_tx_buf, m_rx_buf;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %02h required %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {4'b0000, 1'b0, m_ovr, m_tx_valid, m_rx_valid};
    endfunction

    function automatic logic [7:0] m_ctrl();
        return {6'b000000, m_irq_en, m_en};
    endfunction

    function automatic logic m_irq();
        return m_irq_en & m_en & (m_rx_valid | m_ovr);
    endfunction

    // Byte the responder commits to shifting out next; queued TX data is consumed.
    function automatic logic [7:0] m_take_tx();
        logic [7:0] v;
        v = 8'h00;
        if (m_tx_valid) begin
            v = m_tx_buf;
            m_tx_valid = 1'b0;
        end
        return v;
    endfunction

    function automatic void m_byte_in(input logic [7:0] b, input bit reading);
        if (!m_rx_valid || reading) begin
            m_rx_buf   = b;
            m_rx_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
    endfunction

    always @(negedge clk) begin
        if (quiet) begin
            check("idle_status", dout, m_status());
            check("idle_miso_oe", {7'b0, miso_oe}, 8'h00);
            check("idle_miso", {7'b0, miso}, 8'h00);
`ifdef SPI_SLAVE_IRQ_EN
            check("idle_irq", {7'b0, irq}, {7'b0, m_irq()});
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
        quiet = 1'b0;
        addr  = a;
        din   = d;
        wr_en = 1'b1;
        tick(1);
        wr_en = 1'b0;
        addr  = A_STATUS;
        tick(1);
    endtask

    task automatic cpu_rd(input logic [7:0] a, output logic [7:0] d);
        quiet = 1'b0;
        addr  = a;
        rd_en = 1'b1;
        @(negedge clk);
        d = dout;
        tick(1);
        rd_en = 1'b0;
        addr  = A_STATUS;
        tick(1);
    endtask

    // Mode-0 master, 4 clk per sclk phase. Sends nbytes full bytes then 'partial'
    // extra bits before deselecting; optionally reads RXDATA on the last byte's completion.
    task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1, input int nbytes,
                             input int partial, input bit collide,
                             output logic [7:0] got0, output logic [7:0] got1);
        logic [7:0] mo, cur, got;
        int nb, nloop;
        quiet = 1'b0;
        got0  = 8'h00;
        got1  = 8'h00;
        nloop = nbytes + ((partial > 0) ? 1 : 0);
        cur   = m_en ? m_take_tx() : 8'h00;
        ss_n  = 1'b0;
        for (int b = 0; b < nloop; b++) begin
            mo  = (b == 0) ? b0 : b1;
            nb  = (b < nbytes) ? 8 : partial;
            got = 8'h00;
            for (int i = 0; i < nb; i++) begin
                mosi = mo[7-i];
                tick(4);
                check("miso_bit", {7'b0, miso}, {7'b0, m_en & cur[7-i]});
                check("miso_oe_sel", {7'b0, miso_oe}, {7'b0, m_en});
                check("busy", {7'b0, dout[3]}, {7'b0, m_en});
                got[7-i] = miso;
                sclk = 1'b1;
                if (collide && i == 7) begin
                    tick(2);
                    addr  = A_RX;
                    rd_en = 1'b1;
                    @(negedge clk);
                    check("collide_rd", dout, m_rx_buf);
                    last_collide_rd = dout;
                    tick(1);
                    rd_en = 1'b0;
                    addr  = A_STATUS;
                    tick(1);
                end else begin
                    tick(4);
                end
                if (i == 7 && m_en) m_byte_in(mo, collide);
                sclk = 1'b0;
                if (i == 7 && m_en) cur = m_take_tx();
            end
            if (b == 0) got0 = got;
            else        got1 = got;
        end
        tick(4);
        ss_n = 1'b1;
        mosi = 1'b0;
        tick(5);
    endtask

`ifdef SPI_SLAVE_IRQ_EN
    task automatic irq_watch();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (dout[0]) begin
                seen = 1'b1;
                check("irq_same_cycle", {7'b0, irq}, 8'h00);
                @(negedge clk);
                check("irq_next_cycle", {7'b0, irq}, 8'h01);
            end
        end
        check("irq_rx_valid_seen", {7'b0, seen}, 8'h01);
    endtask
`endif

    initial begin
        #600000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] v, g0, g1, r;
        int op, nb, pb;

        addr = A_STATUS; din = 8'h00; wr_en = 1'b0; rd_en = 1'b0;
        sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
        m_en = 0; m_irq_en = 0; m_rx_valid = 0; m_tx_valid = 0; m_ovr = 0;
        m_tx_buf = 8'h00; m_rx_buf = 8'h00;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // Reset state
        check("rst_miso_oe", {7'b0, miso_oe}, 8'h00);
        cpu_rd(A_CTRL, v);   check("rst_ctrl", v, 8'h00);
        cpu_rd(A_STATUS, v); check("rst_status", v, 8'h00);
        cpu_rd(A_RX, v);     check("rst_rxdata", v, 8'h00);
        quiet = 1'b1; tick(3);
        cpu_wr(A_CTRL, 8'h01); m_en = 1'b1;
        cpu_rd(A_STATUS, v); check("en_status", v, 8'h00);
        quiet = 1'b1; tick(2);

        // Basic exchange
        cpu_wr(A_TX, 8'hA5); m_tx_buf = 8'hA5; m_tx_valid = 1'b1;
        cpu_rd(A_STATUS, v); check("tx_queued_status", v, 8'h02);
        quiet = 1'b1; tick(2);
        spi_frame(8'h3C, 8'h00, 1, 0, 1'b0, g0, g1); quiet = 1'b1;
        check("basic_master_rx", g0, 8'hA5);
        cpu_rd(A_STATUS, v); check("basic_status", v, 8'h01);
        cpu_rd(A_RX, v);     check("basic_rxdata", v, 8'h3C); m_rx_valid = 1'b0;
        cpu_rd(A_STATUS, v); check("basic_rx_cleared", v, 8'h00);
        quiet = 1'b1; tick(2);

        // Underrun and overrun
        spi_frame(8'h11, 8'h22, 2, 0, 1'b0, g0, g1); quiet = 1'b1;
        check("underrun_byte0", g0, 8'h00);
        check("underrun_byte1", g1, 8'h00);
        cpu_rd(A_STATUS, v); check("ovr_status", v, 8'h05);
        cpu_rd(A_RX, v);     check("ovr_rxdata", v, 8'h11); m_rx_valid = 1'b0;
        cpu_wr(A_STATUS, 8'h04); m_ovr = 1'b0;
        cpu_rd(A_STATUS, v); check("ovr_cleared", v, 8'h00);
        quiet = 1'b1; tick(2);

        // Abort after 5 bits, then a clean frame
        spi_frame(8'hF0, 8'h00, 0, 5, 1'b0, g0, g1); quiet = 1'b1;
        cpu_rd(A_STATUS, v); check("abort_status", v, 8'h00);
        quiet = 1'b1; tick(2);
        spi_frame(8'h5A, 8'h00, 1, 0, 1'b0, g0, g1); quiet = 1'b1;
        cpu_rd(A_RX, v); check("after_abort_rx", v, 8'h5A); m_rx_valid = 1'b0;
        quiet = 1'b1; tick(2);

        // RXDATA read colliding with byte completion
        spi_frame(8'h33, 8'h00, 1, 0, 1'b0, g0, g1); quiet = 1'b1; tick(2);
        spi_frame(8'h77, 8'h00, 1, 0, 1'b1, g0, g1); quiet = 1'b1;
        check("collide_old_byte", last_collide_rd, 8'h33);
        cpu_rd(A_STATUS, v); check("collide_status", v, 8'h01);
        cpu_rd(A_RX, v);     check("collide_new_byte", v, 8'h77); m_rx_valid = 1'b0;
        quiet = 1'b1; tick(2);

`ifdef SPI_SLAVE_IRQ_EN
        cpu_wr(A_CTRL, 8'h03); m_irq_en = 1'b1;
        cpu_rd(A_CTRL, v); check("irq_ctrl", v, 8'h03);
        quiet = 1'b1; tick(2);
        fork
            spi_frame(8'hC3, 8'h00, 1, 0, 1'b0, g0, g1);
            irq_watch();
        join
        quiet = 1'b1; tick(1);
        cpu_rd(A_RX, v); check("irq_rxdata", v, 8'hC3); m_rx_valid = 1'b0;
        check("irq_after_read", {7'b0, irq}, 8'h00);
        quiet = 1'b1; tick(2);
`else
        cpu_wr(A_CTRL, 8'h03);
        cpu_rd(A_CTRL, v); check("ctrl_irq_bit_absent", v, 8'h01);
        quiet = 1'b1; tick(2);
`endif

        // Random traffic
        for (int k = 0; k < 80; k++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1: begin
                    r = 8'($urandom);
                    cpu_wr(A_TX, r); m_tx_buf = r; m_tx_valid = 1'b1;
                end
                2: begin
                    cpu_rd(A_RX, v); check("rnd_rxdata", v, m_rx_buf); m_rx_valid = 1'b0;
                end
                3: begin
                    r = 8'($urandom);
                    cpu_wr(A_STATUS, r);
                    if (r[2]) m_ovr = 1'b0;
                end
                4, 5, 6, 7: begin
                    nb = $urandom_range(1, 2);
                    pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
                    spi_frame(8'($urandom), 8'($urandom), nb, pb, 1'b0, g0, g1);
                end
                8: begin
                    r = 8'($urandom);
                    r[0] = ($urandom_range(0, 4) != 0);
                    cpu_wr(A_CTRL, r); m_en = r[0];
`ifdef SPI_SLAVE_IRQ_EN
                    m_irq_en = r[1];
`endif
                    cpu_rd(A_CTRL, v); check("rnd_ctrl", v, m_ctrl());
                end
                default: tick($urandom_range(1, 6));
            endcase
            quiet = 1'b1;
            tick(1);
        end

        quiet = 1'b0;
        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
